// File: rtl/top.sv
// System top: sine table, LFSR noise, flash/SRAM/peripheral decode, UART ID receiver
// driving a two-digit 7-segment display, and a moving-average filter (enabled by TOP_LPF_EN).
module top #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic [8*N-1:0]    address,
  input  logic              read,
  input  logic              write,
  input  logic              rx,
  input  logic [31:0]       noisy_data,
  output logic signed [7:0] out,
  output logic [N-1:0]      lfsr_4bit,
  output logic [2*N-1:0]    lfsr_8bit,
  output logic [8*N-1:0]    lfsr_32bit,
  output logic              CS0,
  output logic              CS1,
  output logic              WP,
  output logic              CE0,
  output logic              CE1,
  output logic              OE0,
  output logic              OE1,
  output logic              WE0,
  output logic              WE1,
  output logic              Control_Module,
  output logic              UART1,
  output logic              rx_busy,
  output logic [7:0]        data,
  output logic [13:0]       Seven_Segment_Display,
  output logic [31:0]       filtered_data
);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {D_IDLE, D_REC, D_DONE} disp_state_t;

  localparam logic [13:0] BLANK = 14'h3FFF;

  logic [5:0]  sine_idx;
  uart_state_t u_state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        id_valid;
  disp_state_t d_state;
  logic [3:0]  tens;
  logic [3:0]  ones;

  // Quarter-wave table of round(127*sin(2*pi*k/64)), mirrored and negated for the rest
  function automatic logic signed [7:0] sine_lut(input logic [5:0] k);
    logic [4:0] h;
    logic [4:0] q;
    logic [6:0] mag;
    h = k[4:0];
    q = (h > 5'd16) ? 5'(6'd32 - {1'b0, h}) : h;
    case (q)
      5'd0:    mag = 7'd0;
      5'd1:    mag = 7'd12;
      5'd2:    mag = 7'd25;
      5'd3:    mag = 7'd37;
      5'd4:    mag = 7'd49;
      5'd5:    mag = 7'd60;
      5'd6:    mag = 7'd71;
      5'd7:    mag = 7'd81;
      5'd8:    mag = 7'd90;
      5'd9:    mag = 7'd98;
      5'd10:   mag = 7'd106;
      5'd11:   mag = 7'd112;
      5'd12:   mag = 7'd117;
      5'd13:   mag = 7'd122;
      5'd14:   mag = 7'd125;
      5'd15:   mag = 7'd126;
      5'd16:   mag = 7'd127;
      default: mag = 7'd0;
    endcase
    return k[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      sine_idx   <= '0;
      out        <= '0;
      lfsr_4bit  <= N'(1);
      lfsr_8bit  <= (2*N)'(1);
      lfsr_32bit <= (8*N)'(1);
    end else begin
      sine_idx   <= sine_idx + 6'd1;
      out        <= sine_lut(sine_idx);
      lfsr_4bit  <= {lfsr_4bit[N-2:0], lfsr_4bit[3] ^ lfsr_4bit[2]};
      lfsr_8bit  <= {lfsr_8bit[2*N-2:0],
                     lfsr_8bit[7] ^ lfsr_8bit[5] ^ lfsr_8bit[4] ^ lfsr_8bit[3]};
      lfsr_32bit <= {lfsr_32bit[8*N-2:0],
                     lfsr_32bit[31] ^ lfsr_32bit[21] ^ lfsr_32bit[1] ^ lfsr_32bit[0]};
    end
  end

  assign CS0            = (address <= 32'h07FF_FFFF);
  assign CS1            = (address >= 32'h0800_0000) && (address <= 32'h0FFF_FFFF);
  assign WP             = CS0 | CS1;
  assign CE0            = (address >= 32'h1000_0000) && (address <= 32'h13FF_FFFF);
  assign CE1            = (address >= 32'h1400_0000) && (address <= 32'h17FF_FFFF);
  // Read takes priority over write when both strobes are asserted
  assign OE0            = CE0 & read;
  assign OE1            = CE1 & read;
  assign WE0            = CE0 & write & ~read;
  assign WE1            = CE1 & write & ~read;
  assign Control_Module = (address >= 32'h44E1_0000) && (address <= 32'h44E1_1FFF);
  assign UART1          = (address >= 32'h4802_2000) && (address <= 32'h4802_2FFF);

  // Start bit must be low for two samples; a high second sample is treated as a glitch
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      u_state  <= U_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      data     <= '0;
      id_valid <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      id_valid <= 1'b0;
      case (u_state)
        U_IDLE: begin
          if (!rx) begin
            u_state <= U_START;
            rx_busy <= 1'b1;
          end
        end
        U_START: begin
          if (!rx) begin
            u_state <= U_DATA;
            bit_cnt <= '0;
          end else begin
            u_state <= U_IDLE;
            rx_busy <= 1'b0;
          end
        end
        U_DATA: begin
          shift   <= {shift[6:0], rx};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) u_state <= U_STOP;
        end
        U_STOP: begin
          if (rx) begin
            data     <= shift;
            id_valid <= 1'b1;
          end
          u_state <= U_IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          u_state <= U_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Digits are recorded blank and only revealed once the "done" ID arrives
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      d_state               <= D_IDLE;
      tens                  <= '0;
      ones                  <= '0;
      Seven_Segment_Display <= BLANK;
    end else if (id_valid) begin
      case (d_state)
        D_IDLE: begin
          if (data == 8'd5) begin
            d_state <= D_REC;
            tens    <= '0;
            ones    <= '0;
          end
        end
        D_REC: begin
          if (data >= 8'd10 && data <= 8'd45) begin
            tens <= ones;
            ones <= 4'(data % 8'd10);
          end else if (data == 8'd46) begin
            d_state               <= D_DONE;
            Seven_Segment_Display <= {seg7(tens), seg7(ones)};
          end
        end
        D_DONE: begin
          if (data == 8'd47) begin
            d_state               <= D_REC;
            tens                  <= '0;
            ones                  <= '0;
            Seven_Segment_Display <= BLANK;
          end else if (data == 8'd0) begin
            d_state               <= D_IDLE;
            Seven_Segment_Display <= BLANK;
          end
        end
        default: begin
          d_state               <= D_IDLE;
          Seven_Segment_Display <= BLANK;
        end
      endcase
    end
  end

`ifdef TOP_LPF_EN
  logic [31:0] x0, x1, x2, x3;
  logic [33:0] lpf_sum;

  assign lpf_sum = {2'b00, x0} + {2'b00, x1} + {2'b00, x2} + {2'b00, x3};

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      x0            <= '0;
      x1            <= '0;
      x2            <= '0;
      x3            <= '0;
      filtered_data <= '0;
    end else begin
      x0            <= noisy_data;
      x1            <= x0;
      x2            <= x1;
      x3            <= x2;
      filtered_data <= 32'(lpf_sum >> 2);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!nRESET) filtered_data <= '0;
    else         filtered_data <= noisy_data;
  end
`endif

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: scoreboard queues hold expected values pushed as stimulus
// is driven and popped when the DUT result is due.
module tb_top;

  localparam real PI = 3.14159265358979;
`ifdef TOP_LPF_EN
  localparam int FDEPTH = 2;
`else
  localparam int FDEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              nRESET = 1'b0;
  logic [31:0]       address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic              rx = 1'b1;
  logic [31:0]       noisy_data = '0;
  logic signed [7:0] out;
  logic [3:0]        lfsr_4bit;
  logic [7:0]        lfsr_8bit;
  logic [31:0]       lfsr_32bit;
  logic CS0, CS1, WP, CE0, CE1, OE0, OE1, WE0, WE1, Control_Module, UART1;
  logic              rx_busy;
  logic [7:0]        data;
  logic [13:0]       Seven_Segment_Display;
  logic [31:0]       filtered_data;

  int checks = 0;
  int failures = 0;

  logic signed [7:0] sine_q[$];
  logic [43:0]       lfsr_q[$];
  logic [10:0]       dec_q[$];
  logic [31:0]       filt_q[$];
  logic [7:0]        data_q[$];
  logic [13:0]       ssd_q[$];

  top #(.N(4)) dut (
    .clk(clk), .nRESET(nRESET), .address(address), .read(read), .write(write),
    .rx(rx), .noisy_data(noisy_data), .out(out), .lfsr_4bit(lfsr_4bit),
    .lfsr_8bit(lfsr_8bit), .lfsr_32bit(lfsr_32bit), .CS0(CS0), .CS1(CS1), .WP(WP),
    .CE0(CE0), .CE1(CE1), .OE0(OE0), .OE1(OE1), .WE0(WE0), .WE1(WE1),
    .Control_Module(Control_Module), .UART1(UART1), .rx_busy(rx_busy), .data(data),
    .Seven_Segment_Display(Seven_Segment_Display), .filtered_data(filtered_data)
  );

  always #5 clk = ~clk;

  function automatic logic signed [7:0] sine_ref(input int k);
    real v;
    v = 127.0 * $sin(2.0 * PI * k / 64.0);
    if (v >= 0.0) return 8'($rtoi(v + 0.5));
    else          return 8'(-$rtoi(-v + 0.5));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    nRESET = 1'b0; rx = 1'b1; read = 1'b0; write = 1'b0; address = '0; noisy_data = '0;
    repeat (2) @(negedge clk);
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nRESET = 1'b1; rx = 1'b1; noisy_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    nRESET = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out !== 8'sd0) begin failures++; $display("[TB] FAIL reset_out got %0d expected 0", out); end
    checks++; if (lfsr_4bit !== 4'd1) begin failures++; $display("[TB] FAIL reset_lfsr4 got %h expected 1", lfsr_4bit); end
    checks++; if (lfsr_8bit !== 8'd1) begin failures++; $display("[TB] FAIL reset_lfsr8 got %h expected 1", lfsr_8bit); end
    checks++; if (lfsr_32bit !== 32'd1) begin failures++; $display("[TB] FAIL reset_lfsr32 got %h expected 1", lfsr_32bit); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_busy got %b expected 0", rx_busy); end
    checks++; if (data !== 8'd0) begin failures++; $display("[TB] FAIL reset_data got %h expected 0", data); end
    checks++; if (Seven_Segment_Display !== 14'h3FFF) begin failures++; $display("[TB] FAIL reset_ssd got %h expected 3fff", Seven_Segment_Display); end
    checks++; if (filtered_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_filtered got %h expected 0", filtered_data); end
    noisy_data = '0;
    @(negedge clk);
    nRESET = 1'b1;
  endtask

  task automatic test_decode();
    logic [44:0] vec [17];
    logic [10:0] exp_v, got_v;
    vec[0]  = {32'h0000_0BCD, 2'b00, 11'b10100000000};
    vec[1]  = {32'h0800_0CBA, 2'b00, 11'b01100000000};
    vec[2]  = {32'h2000_0DEF, 2'b00, 11'b00000000000};
    vec[3]  = {32'h1000_08AD, 2'b10, 11'b00010100000};
    vec[4]  = {32'h1000_08AD, 2'b01, 11'b00010001000};
    vec[5]  = {32'h1000_08AD, 2'b11, 11'b00010100000};
    vec[6]  = {32'h1400_0F32, 2'b10, 11'b00001010000};
    vec[7]  = {32'h1400_0F32, 2'b01, 11'b00001000100};
    vec[8]  = {32'h44E1_0ABC, 2'b00, 11'b00000000010};
    vec[9]  = {32'h4802_2C58, 2'b00, 11'b00000000001};
    vec[10] = {32'h4802_3BBB, 2'b00, 11'b00000000000};
    vec[11] = {32'h07FF_FFFF, 2'b00, 11'b10100000000};
    vec[12] = {32'h17FF_FFFF, 2'b01, 11'b00001000100};
    vec[13] = {32'h1800_0000, 2'b11, 11'b00000000000};
    vec[14] = {32'h44E1_1FFF, 2'b00, 11'b00000000010};
    vec[15] = {32'h44E1_2000, 2'b00, 11'b00000000000};
    vec[16] = {32'h4802_1FFF, 2'b00, 11'b00000000000};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      address = vec[i][44:13];
      read    = vec[i][12];
      write   = vec[i][11];
      dec_q.push_back(vec[i][10:0]);
      #1;
      exp_v = dec_q.pop_front();
      got_v = {CS0, CS1, WP, CE0, CE1, OE0, OE1, WE0, WE1, Control_Module, UART1};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL decode_%0d addr=%h got %b expected %b", i, address, got_v, exp_v);
      end
    end
    @(negedge clk);
    address = '0; read = 1'b0; write = 1'b0;
  endtask

  task automatic test_sine();
    logic signed [7:0] exp_s;
    apply_reset();
    for (int m = 0; m < 70; m++) begin
      sine_q.push_back(sine_ref(m % 64));
      @(negedge clk);
      exp_s = sine_q.pop_front();
      checks++;
      if (out !== exp_s) begin
        failures++;
        $display("[TB] FAIL sine_k%0d got %0d expected %0d", m % 64, out, exp_s);
      end
    end
  endtask

  task automatic test_lfsr();
    logic [3:0]  m4;
    logic [7:0]  m8;
    logic [31:0] m32;
    logic [43:0] e;
    logic [15:0] seen;
    int          distinct;
    apply_reset();
    m4 = 4'd1; m8 = 8'd1; m32 = 32'd1; seen = '0; distinct = 0;
    for (int i = 0; i < 40; i++) begin
      m4  = {m4[2:0], m4[3] ^ m4[2]};
      m8  = {m8[6:0], m8[7] ^ m8[5] ^ m8[4] ^ m8[3]};
      m32 = {m32[30:0], m32[31] ^ m32[21] ^ m32[1] ^ m32[0]};
      lfsr_q.push_back({m4, m8, m32});
      @(negedge clk);
      e = lfsr_q.pop_front();
      checks++;
      if ({lfsr_4bit, lfsr_8bit, lfsr_32bit} !== e) begin
        failures++;
        $display("[TB] FAIL lfsr_step%0d got %h/%h/%h expected %h/%h/%h", i,
                 lfsr_4bit, lfsr_8bit, lfsr_32bit, e[43:40], e[39:32], e[31:0]);
      end
      if (i < 15 && !$isunknown(lfsr_4bit) && !seen[lfsr_4bit]) begin
        seen[lfsr_4bit] = 1'b1;
        distinct++;
      end
      if (i == 14) begin
        checks++;
        if (lfsr_4bit !== 4'd1) begin
          failures++;
          $display("[TB] FAIL lfsr4_period got %h expected 1", lfsr_4bit);
        end
      end
    end
    checks++;
    if (distinct != 15) begin
      failures++;
      $display("[TB] FAIL lfsr4_distinct got %0d expected 15", distinct);
    end
  endtask

  task automatic test_filter();
    logic [31:0] fs [16] = '{32'd0, 32'd0, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd7, 32'd9, 32'd1000, 32'd0, 32'd3};
    logic [31:0] hist [4];
    logic [33:0] s;
    logic [31:0] exp_f;
    int          n;
    apply_reset();
    for (int j = 0; j < 4; j++) hist[j] = '0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (filt_q.size() == FDEPTH) begin
        exp_f = filt_q.pop_front();
        checks++;
        if (filtered_data !== exp_f) begin
          failures++;
          $display("[TB] FAIL filter_%0d got %0d expected %0d", n, filtered_data, exp_f);
        end
        n++;
      end
      noisy_data = fs[i];
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = fs[i];
      s = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
`ifdef TOP_LPF_EN
      filt_q.push_back(s[33:2]);
`else
      filt_q.push_back(fs[i]);
`endif
    end
    while (filt_q.size() > 0) begin
      @(negedge clk);
      exp_f = filt_q.pop_front();
      checks++;
      if (filtered_data !== exp_f) begin
        failures++;
        $display("[TB] FAIL filter_%0d got %0d expected %0d", n, filtered_data, exp_f);
      end
      n++;
    end
    noisy_data = '0;
  endtask

  task automatic test_uart_display();
    logic [7:0]  ids   [14] = '{8'd0, 8'd5, 8'd13, 8'd35, 8'd44, 8'd9, 8'd46,
                                8'd47, 8'd47, 8'd30, 8'd38, 8'd46, 8'd0, 8'd5};
    logic        goods [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  edata [14] = '{8'd0, 8'd5, 8'd13, 8'd35, 8'd44, 8'd9, 8'd46,
                                8'd46, 8'd47, 8'd30, 8'd38, 8'd46, 8'd0, 8'd0};
    logic [13:0] essd  [14] = '{14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF,
                                {7'h12, 7'h19}, {7'h12, 7'h19}, 14'h3FFF, 14'h3FFF,
                                14'h3FFF, {7'h40, 7'h00}, 14'h3FFF, 14'h3FFF};
    logic [10:0] fr;
    logic [7:0]  exp_d;
    logic [13:0] exp_s;
    apply_reset();
    for (int f = 0; f < 14; f++) begin
      fr = {2'b00, ids[f], goods[f]};
      data_q.push_back(edata[f]);
      ssd_q.push_back(essd[f]);
      @(negedge clk);
      checks++;
      if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy_f%0d got %b expected 0", f, rx_busy); end
      for (int b = 10; b >= 0; b--) begin
        rx = fr[b];
        @(negedge clk);
        checks++;
        if (rx_busy !== (b != 0)) begin
          failures++;
          $display("[TB] FAIL rx_busy_f%0d_b%0d got %b expected %b", f, b, rx_busy, (b != 0));
        end
      end
      rx = 1'b1;
      exp_d = data_q.pop_front();
      checks++;
      if (data !== exp_d) begin failures++; $display("[TB] FAIL data_f%0d got %0d expected %0d", f, data, exp_d); end
      @(negedge clk);
      exp_s = ssd_q.pop_front();
      checks++;
      if (Seven_Segment_Display !== exp_s) begin
        failures++;
        $display("[TB] FAIL ssd_f%0d got %h expected %h", f, Seven_Segment_Display, exp_s);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("[TB] FAIL glitch_start got %b expected 1", rx_busy); end
    rx = 1'b1;
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_abort got %b expected 0", rx_busy); end
    repeat (10) @(negedge clk);
    checks++; if (data !== 8'd0) begin failures++; $display("[TB] FAIL glitch_data got %h expected 0", data); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] fr;
    apply_reset();
    fr = {2'b00, 8'h3C, 1'b1};
    data_q.push_back(8'h3C);
    for (int b = 10; b >= 0; b--) begin rx = fr[b]; @(negedge clk); end
    rx = 1'b1;
    checks++;
    begin
      logic [7:0] e;
      e = data_q.pop_front();
      if (data !== e) begin failures++; $display("[TB] FAIL pre_abort_data got %h expected %h", data, e); end
    end
    @(negedge clk);
    fr = {2'b00, 8'hA5, 1'b1};
    for (int b = 10; b >= 5; b--) begin rx = fr[b]; @(negedge clk); end
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_frame_busy got %b expected 1", rx_busy); end
    nRESET = 1'b0; rx = 1'b1;
    @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got %b expected 0", rx_busy); end
    checks++; if (data !== 8'd0) begin failures++; $display("[TB] FAIL abort_data got %h expected 0", data); end
    nRESET = 1'b1;
    @(negedge clk);
    data_q.push_back(8'hA5);
    for (int b = 10; b >= 0; b--) begin rx = fr[b]; @(negedge clk); end
    rx = 1'b1;
    checks++;
    begin
      logic [7:0] e;
      e = data_q.pop_front();
      if (data !== e) begin failures++; $display("[TB] FAIL post_abort_data got %h expected %h", data, e); end
    end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL post_abort_busy got %b expected 0", rx_busy); end
  endtask

  initial begin
    $display("[TB] starting tb_top");
    test_reset();
    test_decode();
    test_sine();
    test_lfsr();
    test_filter();
    test_uart_display();
    test_glitch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
